// File: rtl/capi_tag_pool.sv
// capi_tag_pool -- free-list of resource IDs (tags) kept in a circular FIFO.
//
// After reset the pool fills itself with IDs 0..num_res-1, one per cycle
// (INIT). In RUN it offers the FIFO head for allocation and accepts returned
// IDs at the tail, so IDs are reallocated in the order they were freed.
// A number of IDs ('reserve') can be held back for high-priority requesters.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_free_v/id   return of an ID
//   o_avail_v/id  ID offered for allocation; o_avail_r takes it
//   i_hipri       requester may dip into the reserve
//   o_free_cnt    IDs currently in the pool
//   o_init_done   initial fill complete
//   o_free_err    one-cycle pulse after an illegal free
//
// Optional macro CAPI_TAG_POOL_DBLFREE_CHK_EN adds an in-use bitmap so a free
// of an ID that is not currently allocated is rejected as illegal.
module capi_tag_pool #(
  parameter int id_width = 4,
  parameter int num_res  = 2**id_width,
  parameter int reserve  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_free_v,
  input  logic [id_width-1:0] i_free_id,
  output logic                o_avail_v,
  output logic [id_width-1:0] o_avail_id,
  input  logic                o_avail_r,
  input  logic                i_hipri,
  output logic [id_width:0]   o_free_cnt,
  output logic                o_init_done,
  output logic                o_free_err
);

  localparam int                DEPTH     = 2**id_width;
  localparam logic [id_width:0] NUM_RES_C = (id_width+1)'(num_res);
  localparam logic [id_width:0] RESERVE_C = (id_width+1)'(reserve);
  localparam logic [id_width:0] CNT_ONE   = (id_width+1)'(1);
  localparam logic [id_width-1:0] PTR_ONE = id_width'(1);
  localparam logic [id_width-1:0] LAST_ID = id_width'(num_res-1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [id_width-1:0] rptr_q, rptr_d;
  logic [id_width-1:0] wptr_q, wptr_d;
  logic [id_width:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [id_width-1:0] mem_q [DEPTH];

  logic                in_run, alloc, id_range_bad, dbl_bad, free_bad, free_ok;
  logic                wr_en;
  logic [id_width-1:0] wr_data;

`ifdef CAPI_TAG_POOL_DBLFREE_CHK_EN
  logic [num_res-1:0]  inuse_q, inuse_d;
`endif

  assign in_run      = (state_q == S_RUN);
  assign o_init_done = in_run;
  assign o_free_cnt  = cnt_q;
  assign o_free_err  = err_q;
  assign o_avail_id  = mem_q[rptr_q];
  // Availability looks only at state, count and priority -- never at o_avail_r.
  assign o_avail_v   = in_run && ((cnt_q > RESERVE_C) || (i_hipri && (cnt_q != '0)));
  assign alloc       = o_avail_v && o_avail_r;

  always_comb begin
    id_range_bad = ({1'b0, i_free_id} >= NUM_RES_C);
`ifdef CAPI_TAG_POOL_DBLFREE_CHK_EN
    dbl_bad = !id_range_bad && !inuse_q[i_free_id];
`else
    dbl_bad = 1'b0;
`endif
    // A full pool can only take a free if an allocation makes room this cycle.
    free_bad = i_free_v && (!in_run || id_range_bad || dbl_bad ||
                            ((cnt_q == NUM_RES_C) && !alloc));
    free_ok  = i_free_v && !free_bad;
    err_d    = free_bad;

    state_d = state_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_data = wptr_q;

    if (!in_run) begin
      // During the fill the write pointer doubles as the ID being written.
      wr_en   = 1'b1;
      wr_data = wptr_q;
      wptr_d  = wptr_q + PTR_ONE;
      cnt_d   = cnt_q + CNT_ONE;
      if (wptr_q == LAST_ID) state_d = S_RUN;
    end else begin
      if (alloc) rptr_d = rptr_q + PTR_ONE;
      if (free_ok) begin
        wr_en   = 1'b1;
        wr_data = i_free_id;
        wptr_d  = wptr_q + PTR_ONE;
      end
      if (free_ok && !alloc)      cnt_d = cnt_q + CNT_ONE;
      else if (!free_ok && alloc) cnt_d = cnt_q - CNT_ONE;
    end

`ifdef CAPI_TAG_POOL_DBLFREE_CHK_EN
    inuse_d = inuse_q;
    if (!in_run) begin
      inuse_d = '0;
    end else begin
      if (alloc)   inuse_d[o_avail_id] = 1'b1;
      if (free_ok) inuse_d[i_free_id]  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef CAPI_TAG_POOL_DBLFREE_CHK_EN
      inuse_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef CAPI_TAG_POOL_DBLFREE_CHK_EN
      inuse_q <= inuse_d;
`endif
    end
  end

  // Storage needs no reset: nothing is read before INIT has written it.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_capi_tag_pool.sv
module tb_capi_tag_pool;

`ifdef CAPI_TAG_POOL_DBLFREE_CHK_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_free_v;
  logic [3:0] i_free_id;
  logic       o_avail_v;
  logic [3:0] o_avail_id;
  logic       o_avail_r;
  logic       i_hipri;
  logic [4:0] o_free_cnt;
  logic       o_init_done;
  logic       o_free_err;

  capi_tag_pool #(.id_width(4), .num_res(12), .reserve(2)) dut (
    .clk(clk), .reset(reset),
    .i_free_v(i_free_v), .i_free_id(i_free_id),
    .o_avail_v(o_avail_v), .o_avail_id(o_avail_id), .o_avail_r(o_avail_r),
    .i_hipri(i_hipri), .o_free_cnt(o_free_cnt),
    .o_init_done(o_init_done), .o_free_err(o_free_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, fv;
    logic [3:0] fid;
    logic       ar, hp;
    logic       ev;
    logic [3:0] eid;
    logic [4:0] ecnt;
    logic       eerr, edone;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int rst, int fv, int fid, int ar, int hp,
                              int ev, int eid, int ecnt, int eerr, int edone);
    vec_t v;
    v.rst = rst[0]; v.fv = fv[0]; v.fid = fid[3:0]; v.ar = ar[0]; v.hp = hp[0];
    v.ev = ev[0]; v.eid = eid[3:0]; v.ecnt = ecnt[4:0];
    v.eerr = eerr[0]; v.edone = edone[0];
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // reset state, then the full initial fill
    add(1,0,0,1,1, 0,0,0,0,0);
    for (int k = 0; k < 12; k++) add(0,0,0,1,1, 0,0,k,0,0);
    // drain all 12 IDs in order with hipri
    for (int k = 0; k < 12; k++) add(0,0,0,1,1, 1,k,12-k,0,1);
    add(0,0,0,1,1, 0,0,0,0,1);
    // free 7,3,9 back-to-back; none offered in its own free cycle
    add(0,1,7,1,1, 0,0,0,0,1);
    add(0,1,3,1,1, 1,7,1,0,1);
    add(0,1,9,1,1, 1,3,1,0,1);
    add(0,0,0,1,1, 1,9,1,0,1);
    add(0,0,0,1,1, 0,0,0,0,1);
    // reserve: count 2 blocks low priority, hipri takes one
    add(0,1,4,0,0, 0,0,0,0,1);
    add(0,1,6,0,0, 0,0,1,0,1);
    add(0,0,0,1,0, 0,0,2,0,1);
    add(0,0,0,1,1, 1,4,2,0,1);
    add(0,0,0,1,0, 0,0,1,0,1);
    // out-of-range frees (13, and boundary 12)
    add(0,1,13,0,0, 0,0,1,0,1);
    add(0,0,0,0,0,  0,0,1,1,1);
    add(0,1,12,0,0, 0,0,1,0,1);
    add(0,0,0,0,0,  0,0,1,1,1);
    add(0,0,0,0,0,  0,0,1,0,1);
    // allocate 5, free 5, free 5 again
    add(0,1,5,0,0, 0,0,1,0,1);
    add(0,0,0,1,1, 1,6,2,0,1);
    add(0,0,0,1,1, 1,5,1,0,1);
    add(0,1,5,0,0, 0,0,0,0,1);
    add(0,1,5,0,0, 0,0,1,0,1);
    add(0,0,0,0,0, 0,0,(DBL!=0)?1:2,DBL,1);
    add(0,0,0,0,0, 0,0,(DBL!=0)?1:2,0,1);
    // mid-operation reset reruns INIT and restores all 12
    add(1,0,0,0,0, 0,0,(DBL!=0)?1:2,0,1);
    add(1,0,0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 12; k++) add(0,0,0,0,0, 0,0,k,0,0);
    add(0,0,0,0,0, 1,0,12,0,1);
    // full pool: free without allocation is illegal
    add(0,1,3,0,0, 1,0,12,0,1);
    add(0,0,0,0,0, 1,0,12,1,1);
    // full pool: free together with allocation (bitmap build rejects it,
    // since nothing is in use when the pool is full)
    add(0,1,3,1,0, 1,0,12,0,1);
    add(0,0,0,0,0, 1,1,(DBL!=0)?11:12,DBL,1);
    add(0,0,0,0,0, 1,1,(DBL!=0)?11:12,0,1);

    reset = 1'b1; i_free_v = 1'b0; i_free_id = '0; o_avail_r = 1'b0; i_hipri = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; i_free_v = tbl[i].fv; i_free_id = tbl[i].fid;
      o_avail_r = tbl[i].ar; i_hipri = tbl[i].hp;
      #1;
      chk("avail_v",   i, {7'd0, o_avail_v},   {7'd0, tbl[i].ev});
      if (tbl[i].ev) chk("avail_id", i, {4'd0, o_avail_id}, {4'd0, tbl[i].eid});
      chk("free_cnt",  i, {3'd0, o_free_cnt},  {3'd0, tbl[i].ecnt});
      chk("free_err",  i, {7'd0, o_free_err},  {7'd0, tbl[i].eerr});
      chk("init_done", i, {7'd0, o_init_done}, {7'd0, tbl[i].edone});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capi_tag_pool.md
CAPI_TAG_POOL -- requirements
Module: capi_tag_pool

Interface
REQ-001 Parameter id_width, default 4: width in bits of a resource ID.
REQ-002 Parameter num_res, default 2**id_width: number of managed IDs (0..num_res-1); legal range 2..2**id_width.
REQ-003 Parameter reserve, default 0: number of IDs held back for high-priority requesters; legal range 0..num_res-1.
REQ-004 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_free_v  input  1  a free (return) of an ID is presented this cycle.
REQ-007 i_free_id  input  id_width  ID being returned; valid when i_free_v=1.
REQ-008 o_avail_v  output  1  an ID is offered for allocation.
REQ-009 o_avail_id  output  id_width  the offered ID; valid when o_avail_v=1.
REQ-010 o_avail_r  input  1  consumer takes the offered ID; allocation occurs when o_avail_v & o_avail_r.
REQ-011 i_hipri  input  1  current requester is high priority and may consume the reserve.
REQ-012 o_free_cnt  output  id_width+1  number of IDs currently in the pool.
REQ-013 o_init_done  output  1  the initial fill is complete.
REQ-014 o_free_err  output  1  registered one-cycle pulse flagging an illegal free.

Function
REQ-015 The pool SHALL be a circular FIFO of depth 2**id_width, with read pointer, write pointer and occupancy counter; both pointers SHALL wrap modulo 2**id_width.
REQ-016 FSM states SHALL be INIT and RUN; reset SHALL enter INIT.
REQ-017 In INIT, the block SHALL write one ID per cycle, 0,1,...,num_res-1 in order; it SHALL enter RUN on the cycle after ID num_res-1 is written, so INIT lasts exactly num_res cycles.
REQ-018 o_init_done SHALL be 0 in INIT and 1 in RUN; o_avail_v SHALL be 0 in INIT.
REQ-019 Any i_free_v during INIT SHALL be dropped and flagged as an error.
REQ-020 In RUN, o_avail_id SHALL equal the FIFO head (combinational read), so IDs are allocated in the order they were freed.
REQ-021 In RUN, o_avail_v SHALL be 1 when o_free_cnt > reserve, or when i_hipri=1 and o_free_cnt > 0; otherwise it SHALL be 0.
REQ-022 A legal free SHALL be written at the tail and SHALL be offerable from the next cycle; a free SHALL never be offered in the same cycle it arrives.
REQ-023 A simultaneous legal free and allocation SHALL leave o_free_cnt unchanged; a free alone SHALL add 1 and an allocation alone SHALL subtract 1.
REQ-024 A free SHALL be illegal when i_free_id >= num_res, or when o_free_cnt == num_res and no allocation occurs that same cycle.
REQ-025 An illegal free SHALL NOT modify the FIFO, the pointers or o_free_cnt, and SHALL set o_free_err for exactly the following cycle.
REQ-026 o_avail_v SHALL not depend combinationally on o_avail_r.

Reset
REQ-027 While reset=1, and on the cycle after it is released, the block SHALL hold: state=INIT, pointers=0, o_free_cnt=0, o_avail_v=0, o_init_done=0, o_free_err=0.
REQ-028 Reset asserted mid-operation SHALL discard every outstanding allocation and rerun INIT, restoring all num_res IDs.

Configuration
REQ-029 With macro CAPI_TAG_POOL_DBLFREE_CHK_EN defined, the block SHALL keep an in-use bitmap of num_res bits: allocation sets the bit, a legal free clears it, INIT clears all bits, and a free of an ID whose bit is clear SHALL be illegal per REQ-025.
REQ-030 Without CAPI_TAG_POOL_DBLFREE_CHK_EN, no bitmap SHALL exist and a double free SHALL be detected only through REQ-024.

Verification (id_width=4, num_res=12, reserve=2)
REQ-031 Release reset, hold o_avail_r=1 and i_hipri=1 -> o_init_done rises after 12 cycles, then IDs 0..11 are allocated in order and o_avail_v drops with o_free_cnt=0.
REQ-032 From empty, free 7, then 3, then 9 on consecutive cycles -> they are re-allocated as 7, 3, 9; none is offered in its own free cycle.
REQ-033 Pool at count 2, i_hipri=0 -> o_avail_v=0; set i_hipri=1 -> o_avail_v=1 and allocation takes count to 1.
REQ-034 Free ID 13, or free with count=12 and no allocation -> o_free_err pulses for 1 cycle and count is unchanged; a simultaneous free and allocation at count=12 -> no error and count stays 12.
REQ-035 With CAPI_TAG_POOL_DBLFREE_CHK_EN: allocate 5, free 5, free 5 again -> the second free flags an error; without the macro the same stimulus gives no error.
REQ-036 Assert reset with 6 IDs outstanding -> INIT reruns, and count returns to 12 after 12 cycles.
